// File: rtl/clk_divider_multi_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel clock divider.
package clk_divider_multi_pkg;

    localparam int HALF_STOPPED = 32'sd0;

    function automatic int ch_width(input int n);
        int w;
        w = 32'sd0;
        for (int i = 0; i < 32'sd5; i++) begin
            if ((32'sd1 << w) < n) begin
                w = w + 32'sd1;
            end else begin
                w = w;
            end
        end
        if (w == 32'sd0) begin
            return 32'sd1;
        end else begin
            return w;
        end
    endfunction

    function automatic longint unsigned reset_half(input longint unsigned clk_freq,
                                                   input longint unsigned def_freq);
        return clk_freq / (64'd2 * def_freq);
    endfunction

endpackage

// File: rtl/clk_divider_multi_ch.sv
// One divider channel: half-period counter, active/pending half-period pair and registered outputs.
module clk_divider_ch
    import clk_divider_multi_pkg::*;
#(
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] RST_HALF = {{(CNT_W-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] STOP_HALF = CNT_W'(HALF_STOPPED);

    logic [CNT_W-1:0] count_r, active_r, pending_r;
    logic             pend_valid_r, clk_div_r, tick_r;
    logic [CNT_W-1:0] count_s, active_s, pending_s, apply_val_s;
    logic             pend_valid_s, clk_div_s, tick_s;
    logic             stopped_s, terminal_s, apply_s;

    // Next-state: new half-periods only ever land on a boundary where count restarts at 0.
    always_comb begin
        stopped_s  = (active_r == STOP_HALF);
        terminal_s = !stopped_s && (count_r == (active_r - ONE));
        apply_s    = sync || stopped_s || terminal_s;
        if (wr) begin
            apply_val_s = wr_half;
        end else if (pend_valid_r) begin
            apply_val_s = pending_r;
        end else begin
            apply_val_s = active_r;
        end

        count_s      = count_r;
        clk_div_s    = clk_div_r;
        tick_s       = 1'b0;
        active_s     = active_r;
        pending_s    = pending_r;
        pend_valid_s = pend_valid_r;

        if (sync) begin
            count_s   = ZERO;
            clk_div_s = 1'b0;
        end else if (stopped_s) begin
            count_s   = ZERO;
        end else if (terminal_s) begin
            count_s   = ZERO;
            clk_div_s = ~clk_div_r;
            tick_s    = 1'b1;
        end else begin
            count_s   = count_r + ONE;
        end

        if (apply_s) begin
            active_s     = apply_val_s;
            pend_valid_s = 1'b0;
        end else if (wr) begin
            pending_s    = wr_half;
            pend_valid_s = 1'b1;
        end else begin
            pending_s    = pending_r;
        end
    end

    // Channel state register; reset discards any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r      <= ZERO;
            active_r     <= RST_HALF;
            pending_r    <= RST_HALF;
            pend_valid_r <= 1'b0;
            clk_div_r    <= 1'b0;
            tick_r       <= 1'b0;
        end else begin
            count_r      <= count_s;
            active_r     <= active_s;
            pending_r    <= pending_s;
            pend_valid_r <= pend_valid_s;
            clk_div_r    <= clk_div_s;
            tick_r       <= tick_s;
        end
    end

    assign clk_div = clk_div_r;
    assign tick    = tick_r;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel runtime-programmable clock divider: decodes the write port onto NUM_CH channels.
module clk_divider_multi
    import clk_divider_multi_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int DEF_FREQ = 1,
    parameter int CH_W     = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_half,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] RST_HALF =
        CNT_W'(reset_half(64'(CLK_FREQ), 64'(DEF_FREQ)));

    logic [NUM_CH-1:0] wr_sel_s;

    // Out-of-range channel numbers match no instance and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel_s[i] = wr_en && (wr_ch == CH_W'(i));

        clk_divider_ch #(
            .CNT_W    (CNT_W),
            .RST_HALF (RST_HALF)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sync    (sync),
            .wr      (wr_sel_s[i]),
            .wr_half (wr_half),
            .clk_div (clk_div[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench: 100 Hz clock, 10 Hz default -> reset half-period of 5 clocks.
module tb_clk_divider_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sync = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = 2'd0;
    logic [31:0] wr_half = 32'd0;
    logic [3:0]  clk_div, tick;
    logic        wr_en3 = 1'b0;
    logic [1:0]  wr_ch3 = 2'd0;
    logic [2:0]  clk_div3, tick3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clk_divider_multi #(.CLK_FREQ(100), .NUM_CH(4), .CNT_W(32), .DEF_FREQ(10)) u_dut (
        .clk(clk), .rst(rst), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_half(wr_half), .clk_div(clk_div), .tick(tick)
    );

    // Three channels so that wr_ch = 3 is an out-of-range select.
    clk_divider_multi #(.CLK_FREQ(100), .NUM_CH(3), .CNT_W(32), .DEF_FREQ(10)) u_dut3 (
        .clk(clk), .rst(rst), .sync(sync), .wr_en(wr_en3), .wr_ch(wr_ch3),
        .wr_half(wr_half), .clk_div(clk_div3), .tick(tick3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_toggle(input string tag, input int ch, input int n, input logic lvl);
        for (int i = 1; i < n; i++) begin
            step();
            check_val(tag, 32'(tick[ch]), 32'd0);
        end
        step();
        check_val(tag, 32'(tick[ch]), 32'd1);
        check_val(tag, 32'(clk_div[ch]), 32'(lvl));
    endtask

    task automatic wr_cmd(input logic [1:0] ch, input logic [31:0] val);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_half = val;
        step();
        wr_en   = 1'b0;
    endtask

    logic [3:0] sync_ticks [5] = '{4'b0000, 4'b0000, 4'b0011, 4'b0100, 4'b1000};

    initial begin
        step();
        check_val("rst_div", 32'(clk_div), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        check_val("rst_div3", 32'(clk_div3), 32'd0);
        rst = 1'b1;

        wait_toggle("rst_t5", 0, 5, 1'b1);
        check_val("rst_all_tick", 32'(tick), 32'hF);
        check_val("rst_all_div", 32'(clk_div), 32'hF);
        wait_toggle("rst_t10", 0, 5, 1'b0);
        wait_toggle("rst_t15", 0, 5, 1'b1);

        step();
        wr_cmd(2'd1, 32'd3);
        wait_toggle("chg_mid_a", 1, 3, 1'b0);
        wait_toggle("chg_mid_b", 1, 3, 1'b1);

        step();
        wr_cmd(2'd0, 32'd3);
        check_val("chg_term_tick", 32'(tick[0]), 32'd1);
        check_val("chg_term_div", 32'(clk_div[0]), 32'd1);
        wait_toggle("chg_term_next", 0, 3, 1'b0);

        step();
        step();
        wr_cmd(2'd2, 32'd0);
        wait_toggle("stop_bound", 2, 4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("stop_tick", 32'(tick[2]), 32'd0);
            check_val("stop_hold", 32'(clk_div[2]), 32'd1);
        end
        wr_cmd(2'd2, 32'd2);
        wait_toggle("restart", 2, 2, 1'b0);

        wr_cmd(2'd0, 32'd1);
        wait_toggle("h1_apply", 0, 1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check_val("h1_tick", 32'(tick[0]), 32'd1);
            check_val("h1_div", 32'(clk_div[0]), 32'(i % 2));
        end

        wr_cmd(2'd3, 32'd7);
        wr_cmd(2'd3, 32'd4);
        wait_toggle("lww_apply", 3, 1, 1'b1);
        wait_toggle("lww_p1", 3, 4, 1'b0);
        wait_toggle("lww_p2", 3, 4, 1'b1);

        wr_cmd(2'd0, 32'd3);
        wr_cmd(2'd3, 32'd5);
        sync    = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd2;
        wr_half = 32'd4;
        step();
        sync    = 1'b0;
        wr_en   = 1'b0;
        check_val("sync_div", 32'(clk_div), 32'd0);
        check_val("sync_tick", 32'(tick), 32'd0);
        check_val("sync_div3", 32'(clk_div3), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("sync_align", 32'(tick), 32'(sync_ticks[i]));
        end
        check_val("sync_div_all", 32'(clk_div), 32'hF);
        check_val("sync_tick3", 32'(tick3), 32'h7);

        wr_en3  = 1'b1;
        wr_ch3  = 2'd3;
        wr_half = 32'd1;
        step();
        wr_en3  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("ill_quiet", 32'(tick3), 32'd0);
        end
        step();
        check_val("ill_tick", 32'(tick3), 32'h7);
        check_val("ill_div", 32'(clk_div3), 32'd0);

        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_half = 32'd9;
        step();
        wr_en   = 1'b0;
        check_val("ill_after", 32'(tick3), 32'd0);

        #2;
        rst = 1'b0;
        #1;
        check_val("arst_div", 32'(clk_div), 32'd0);
        check_val("arst_tick", 32'(tick), 32'd0);
        check_val("arst_div3", 32'(clk_div3), 32'd0);
        step();
        rst = 1'b1;
        wait_toggle("post_rst", 0, 5, 1'b1);
        check_val("post_rst_all", 32'(tick), 32'hF);
        check_val("post_rst_all3", 32'(tick3), 32'h7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Multi-channel, runtime-programmable successor of the fixed single-frequency clock divider.
- NUM_CH independent channels. Each channel produces a 50% duty divided clock level (clk_div) and a one-cycle enable strobe (tick) on every toggle.
- Each channel's half-period count is written at runtime through a simple write port and takes effect glitch-free at the next period boundary.
- A sync input phase-aligns all channels. The block sits between the board clock and the FSM/display logic that need slow enables.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 32, width of counters and half-period registers.
- DEF_FREQ, 1, reset output frequency in Hz for every channel; reset half-period = CLK_FREQ/(2*DEF_FREQ).
- CH_W, max(1, clog2(NUM_CH)), derived width of the channel select; not to be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sync  in  1  synchronous restart of all channels (counters to 0, clk_div to 0).
- wr_en  in  1  write strobe for the half-period register.
- wr_ch  in  CH_W  channel select for the write.
- wr_half  in  CNT_W  new half-period, in input clocks; 0 = channel stopped.
- clk_div  out  NUM_CH  divided clock level per channel.
- tick  out  NUM_CH  one-cycle pulse per channel, asserted in the cycle clk_div toggles.

Behaviour:
- Reset (rst=0, asynchronous):
  - every count = 0, clk_div = 0, tick = 0;
  - active_half = pending_half = CLK_FREQ/(2*DEF_FREQ); pend_valid = 0.
- Per channel, with active_half = H > 0:
  - count runs 0..H-1.
  - At count == H-1: count <= 0, clk_div toggles, tick = 1 for exactly that one registered cycle. Otherwise count increments and tick = 0.
  - Output period = 2H input clocks, duty exactly 50%.
  - First toggle after reset or sync occurs H clocks later.
- H = 1: clk_div toggles every cycle (clk/2) and tick stays high continuously.
- H = 0 (stopped): count held at 0, clk_div holds its current level, tick = 0.
- Write (wr_en=1, wr_ch < NUM_CH): wr_half goes to pending_half[wr_ch] and sets pend_valid.
  - Writes with wr_ch >= NUM_CH are ignored.
  - A second write before the pending value is applied overwrites it (last write wins).
- Apply point: pending_half is copied to active_half and pend_valid is cleared when any of these holds:
  - the channel reaches its terminal cycle (count == H-1); the new H is used from the following count = 0;
  - the channel is stopped (H = 0); the value applies the cycle after the write, and count starts from 0;
  - sync is asserted.
- Write on the exact terminal cycle: the written value is applied at that boundary, with no extra period at the old H.
- Shrinking H never causes a runaway count, because application happens only at a boundary with count reset to 0. Comparisons are equality-based, so count never exceeds H-1.
- sync=1: all channels set count = 0, clk_div = 0, tick = 0, and apply any pending values in the same cycle. sync has priority over terminal-count behaviour. A write in the same cycle as sync is applied directly as the new active_half.
- Reset mid-operation discards pending writes.
- Arithmetic is unsigned CNT_W. The reset-value division is evaluated at elaboration; DEF_FREQ is required to satisfy CLK_FREQ/(2*DEF_FREQ) >= 1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package/include holds: the reset half-period constant function (CLK_FREQ, DEF_FREQ), the clog2 helper for CH_W, and the "H=0 means stopped" encoding constant.
- One sub-module, clk_divider_ch: a single channel with count, active/pending registers and outputs. Ports: clk, rst, sync, wr, wr_half, clk_div, tick. The top decodes wr_ch and instantiates NUM_CH copies via generate.

Test Plan:
- Reset defaults: CLK_FREQ=100, DEF_FREQ=10. Release rst → every channel toggles at cycles 5, 10, 15…; tick high only in those cycles; clk_div starts at 0.
- Runtime change at boundary: ch1 running with H=5; write 3 at count=1 → period 10 completes, then toggles every 3 clocks. Write 3 exactly at count=4 → next toggle after 3 clocks.
- Stop/start: write 0 to ch2 while clk_div=1 → clk_div holds 1, tick stays 0. Write 2 → counting starts next cycle, first toggle (to 0) 2 clocks later.
- H=1 and last-write-wins: write 1 to ch0 → clk_div toggles every cycle, tick constant 1. Write 7 then 4 to ch3 within one period → only 4 takes effect.
- sync alignment: channels with H=3,4,5 free-running; pulse sync → all clk_div=0 and count=0 next cycle; toggles at +3/+4/+5 from sync. Pending values applied at sync.
- Reset mid-operation and illegal channel: assert rst asynchronously mid-count → outputs 0 immediately, pending cleared. Write with wr_ch=NUM_CH → no channel changes.
